// File: rtl/async_queue_enq_ptr.sv
// async_queue_enq_ptr: enqueue-side Gray write-pointer controller for a 32-entry async queue
// Optional read-pointer protocol checker enabled by defining ASYNC_QUEUE_PTR_CHECK_EN.
module async_queue_enq_ptr #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [DATA_W-1:0] enq_bits,
  output logic              mem_wen,
  output logic [4:0]        mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [5:0]        wptr_d,
  output logic              wptr_en,
  input  logic [5:0]        rptr_gray_sync,
  output logic [5:0]        level,
  output logic              ptr_err
);
  logic [5:0] r_bin;
  logic [5:0] r_gray;
  logic [5:0] w_bin_nxt;
  logic [5:0] w_gray_nxt;
  logic [5:0] w_rbin;
  logic       w_full;
  logic       w_fire;
  // Full when the write pointer is exactly one lap (32 entries) ahead of the read pointer
  assign w_full     = r_gray == {~rptr_gray_sync[5:4], rptr_gray_sync[3:0]};
  assign enq_ready  = reset & ~w_full;
  assign w_fire     = enq_valid & enq_ready;
  assign w_bin_nxt  = r_bin + 6'd1;
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
  assign mem_wen    = w_fire;
  assign mem_waddr  = r_bin[4:0];
  assign mem_wdata  = enq_bits;
  assign wptr_en    = w_fire | ~reset;
  assign wptr_d     = reset ? w_gray_nxt : 6'h00;
  // Gray-to-binary of the synchronized read pointer, MSB downwards
  always_comb begin
    w_rbin[5] = rptr_gray_sync[5];
    for (int i = 4; i >= 0; i--) w_rbin[i] = w_rbin[i+1] ^ rptr_gray_sync[i];
  end
  assign level = r_bin - w_rbin;
  // Write count and its Gray image advance together on every accepted beat
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_bin  <= 6'd0;
      r_gray <= 6'd0;
    end else if (w_fire) begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
    end
  end
`ifdef ASYNC_QUEUE_PTR_CHECK_EN
  logic [5:0] r_rptr_prev;
  logic       r_err;
  logic [5:0] w_rdiff;
  logic       w_multi;
  assign w_rdiff = r_rptr_prev ^ rptr_gray_sync;
  assign w_multi = (w_rdiff & (w_rdiff - 6'd1)) != 6'd0;
  // Sticky flag for a non-Gray read pointer step or an impossible occupancy
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rptr_prev <= 6'd0;
      r_err       <= 1'b0;
    end else begin
      r_rptr_prev <= rptr_gray_sync;
      r_err       <= r_err | w_multi | (level > 6'd32);
    end
  end
  assign ptr_err = r_err;
`else
  assign ptr_err = 1'b0;
`endif
endmodule

// File: tb/tb_async_queue_enq_ptr.sv
// tb_async_queue_enq_ptr: randomized self-checking bench against a count-based queue model
module tb_async_queue_enq_ptr;
  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_bits;
  logic        mem_wen;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [5:0]  wptr_d;
  logic        wptr_en;
  logic [5:0]  rptr_gray_sync;
  logic [5:0]  level;
  logic        ptr_err;
  int n_chk = 0;
  int n_err = 0;
  int m_w = 0;
  int m_r = 0;
  bit m_err = 0;
  logic [5:0] m_prev = 0;
  logic [5:0] gtab [64];
  int         btab [64];
  async_queue_enq_ptr #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_bits(enq_bits), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wptr_d(wptr_d), .wptr_en(wptr_en), .rptr_gray_sync(rptr_gray_sync),
    .level(level), .ptr_err(ptr_err)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    int  lvl;
    bit  full, rdy, fire;
    @(negedge clock);
    lvl  = (m_w - btab[rptr_gray_sync]) & 63;
    full = lvl == 32;
    rdy  = reset && !full;
    fire = enq_valid && rdy;
    check("enq_ready", enq_ready, rdy);
    check("mem_wen", mem_wen, fire);
    check("wptr_en", wptr_en, fire || !reset);
    check("wptr_d", wptr_d, reset ? gtab[(m_w + 1) % 64] : 6'h00);
    check("level", level, lvl);
    if (fire) begin
      check("mem_waddr", mem_waddr, m_w % 32);
      check("mem_wdata", mem_wdata, enq_bits);
    end
`ifdef ASYNC_QUEUE_PTR_CHECK_EN
    check("ptr_err", ptr_err, m_err);
`else
    check("ptr_err", ptr_err, 1'b0);
`endif
    @(posedge clock);
    if (!reset) begin
      m_w = 0; m_err = 0; m_prev = 0;
    end else begin
      if ($countones(m_prev ^ rptr_gray_sync) > 1 || lvl > 32) m_err = 1;
      m_prev = rptr_gray_sync;
      if (fire) m_w = (m_w + 1) % 64;
    end
    #1;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) begin
      gtab[i] = 6'(i ^ (i >> 1));
      btab[gtab[i]] = i;
    end
    reset = 0; enq_valid = 1; enq_bits = $urandom; rptr_gray_sync = 0;
    repeat (3) step();
    reset = 1;
    for (int i = 0; i < 33; i++) begin
      enq_bits = $urandom;
      step();
    end
    enq_valid = 0; rptr_gray_sync = 6'h01;
    step();
    enq_valid = 1; enq_bits = $urandom;
    step();
    reset = 0; enq_valid = 0;
    step();
    reset = 1; rptr_gray_sync = 0;
    step();
    enq_valid = 1;
    repeat (10) begin
      enq_bits = $urandom;
      step();
    end
    reset = 0;
    step();
    reset = 1;
    repeat (3) begin
      enq_bits = $urandom;
      step();
    end
    reset = 0;
    step();
    reset = 1;
    for (int i = 0; i < 100; i++) begin
      rptr_gray_sync = gtab[m_w];
      enq_valid = ($urandom_range(0, 7) != 0);
      enq_bits = $urandom;
      step();
    end
    reset = 0; rptr_gray_sync = 0;
    step();
    reset = 1; m_r = 0;
    for (int i = 0; i < 300; i++) begin
      if (((m_w - m_r) & 63) != 0 && $urandom_range(0, 2) == 0) m_r = (m_r + 1) % 64;
      rptr_gray_sync = gtab[m_r];
      enq_valid = $urandom_range(0, 1);
      enq_bits = $urandom;
      step();
    end
    reset = 0; enq_valid = 0; rptr_gray_sync = 0;
    step();
    reset = 1;
    step();
    rptr_gray_sync = 6'h03;
    repeat (4) step();
    rptr_gray_sync = 6'h02;
    repeat (2) step();
    reset = 0;
    step();
    reset = 1; rptr_gray_sync = 0;
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
